falu_wb_buffer: RTL and testbench

//  Receiving end of the FALU response interface, on the RCU side. Captures every FALU response
//  (result, prd, rob index, fflags, float flag) in a small FIFO. Drains one entry per cycle to the
//  RCU writeback/ROB-complete port under valid/ready. Drives a stall back to FALU issue, because

---
 rtl/falu_wb_buffer_pkg.sv | 32 +++
 rtl/falu_wb_buffer_sync_fifo.sv | 63 ++++++
 rtl/falu_wb_buffer.sv | 90 +++++++++
 tb/tb_falu_wb_buffer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/falu_wb_buffer_pkg.sv
// Shared widths and packed-entry layout for the FALU writeback buffer.
// Entry layout (MSB..LSB): {float, fflags_valid, fflags, result, rob, prd}.
package falu_wb_buffer_pkg;

  localparam int XLEN               = 64;
  localparam int ROB_INDEX_WIDTH    = 6;
  localparam int PHY_REG_ADDR_WIDTH = 7;
  localparam int FFLAGS_W           = 5;

  localparam int FALU_WB_PRD_LSB   = 0;
  localparam int FALU_WB_ROB_LSB   = FALU_WB_PRD_LSB + PHY_REG_ADDR_WIDTH;
  localparam int FALU_WB_RES_LSB   = FALU_WB_ROB_LSB + ROB_INDEX_WIDTH;
  localparam int FALU_WB_FF_LSB    = FALU_WB_RES_LSB + XLEN;
  localparam int FALU_WB_FFV_BIT   = FALU_WB_FF_LSB + FFLAGS_W;
  localparam int FALU_WB_FLOAT_BIT = FALU_WB_FFV_BIT + 1;
  localparam int FALU_WB_ENTRY_W   = FALU_WB_FLOAT_BIT + 1;

  typedef logic [FALU_WB_ENTRY_W-1:0] falu_wb_entry_t;

  // Flags of ops that do not produce fflags are zeroed here so nothing downstream has to mask.
  function automatic falu_wb_entry_t falu_wb_pack(
    input logic [PHY_REG_ADDR_WIDTH-1:0] prd,
    input logic [ROB_INDEX_WIDTH-1:0]    rob,
    input logic [XLEN-1:0]               result,
    input logic [FFLAGS_W-1:0]           fflags,
    input logic                          fflags_vld,
    input logic                          float_dst
  );
    return {float_dst, fflags_vld, (fflags_vld ? fflags : {FFLAGS_W{1'b0}}), result, rob, prd};
  endfunction

endpackage

// File: rtl/falu_wb_buffer_sync_fifo.sv
// Synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module falu_wb_buffer_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/falu_wb_buffer.sv
// RCU-side buffer for FALU responses: FIFO toward writeback, stall back to FALU issue.
// Optional FALU_WB_BYPASS_EN: an empty buffer forwards a response to wb_* in the same cycle.
module falu_wb_buffer
  import falu_wb_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          falu_resp_valid_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] falu_prd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    falu_rob_index_i,
  input  logic [XLEN-1:0]               falu_result_i,
  input  logic [FFLAGS_W-1:0]           falu_fflags_i,
  input  logic                          falu_fflags_valid_i,
  input  logic                          falu_float_i,
  output logic                          falu_stall_o,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o,
  output logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o,
  output logic [XLEN-1:0]               wb_data_o,
  output logic [FFLAGS_W-1:0]           wb_fflags_o,
  output logic                          wb_fflags_valid_o,
  output logic                          wb_float_o,
  output logic                          overflow_err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  falu_wb_entry_t   new_entry, head_entry, wb_entry;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             push_req, bypass, wb_valid;
  logic             overflow_err_q, overflow_err_d;

  assign push_req  = falu_resp_valid_i && !flush_i;
  assign new_entry = falu_wb_pack(falu_prd_addr_i, falu_rob_index_i, falu_result_i,
                                  falu_fflags_i, falu_fflags_valid_i, falu_float_i);

`ifdef FALU_WB_BYPASS_EN
  assign bypass = push_req && fifo_empty && wb_ready_i;
`else
  assign bypass = 1'b0;
`endif

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign fifo_pop  = !fifo_empty && wb_ready_i && !flush_i;
  assign fifo_push = push_req && !bypass && (!fifo_full || fifo_pop);

  falu_wb_buffer_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FALU_WB_ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (new_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign overflow_err_d = overflow_err_q || (push_req && fifo_full && !fifo_pop);

  always_ff @(posedge clk) begin
    if (rst) overflow_err_q <= 1'b0;
    else     overflow_err_q <= overflow_err_d;
  end

  // Unused FIFO slots may hold stale data, so fields are forced to zero whenever not valid.
  assign wb_valid = bypass || !fifo_empty;
  assign wb_entry = !wb_valid ? '0 : (bypass ? new_entry : head_entry);

  assign wb_valid_o        = wb_valid;
  assign wb_prd_addr_o     = wb_entry[FALU_WB_PRD_LSB +: PHY_REG_ADDR_WIDTH];
  assign wb_rob_index_o    = wb_entry[FALU_WB_ROB_LSB +: ROB_INDEX_WIDTH];
  assign wb_data_o         = wb_entry[FALU_WB_RES_LSB +: XLEN];
  assign wb_fflags_o       = wb_entry[FALU_WB_FF_LSB +: FFLAGS_W];
  assign wb_fflags_valid_o = wb_entry[FALU_WB_FFV_BIT];
  assign wb_float_o        = wb_entry[FALU_WB_FLOAT_BIT];

  assign falu_stall_o   = (fifo_count == CNT_W'(DEPTH));
  assign overflow_err_o = overflow_err_q;

endmodule

// File: tb/tb_falu_wb_buffer.sv
// Scoreboard bench for falu_wb_buffer: expected entries queued at drive time, checked on handshake.
module tb_falu_wb_buffer;
  import falu_wb_buffer_pkg::*;

  localparam int DEPTH = 4;
`ifdef FALU_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          flush_i;
  logic                          falu_resp_valid_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] falu_prd_addr_i;
  logic [ROB_INDEX_WIDTH-1:0]    falu_rob_index_i;
  logic [XLEN-1:0]               falu_result_i;
  logic [FFLAGS_W-1:0]           falu_fflags_i;
  logic                          falu_fflags_valid_i;
  logic                          falu_float_i;
  logic                          falu_stall_o;
  logic                          wb_valid_o;
  logic                          wb_ready_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o;
  logic [XLEN-1:0]               wb_data_o;
  logic [FFLAGS_W-1:0]           wb_fflags_o;
  logic                          wb_fflags_valid_o;
  logic                          wb_float_o;
  logic                          overflow_err_o;

  always #5 clk = ~clk;

  falu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .falu_resp_valid_i   (falu_resp_valid_i),
    .falu_prd_addr_i     (falu_prd_addr_i),
    .falu_rob_index_i    (falu_rob_index_i),
    .falu_result_i       (falu_result_i),
    .falu_fflags_i       (falu_fflags_i),
    .falu_fflags_valid_i (falu_fflags_valid_i),
    .falu_float_i        (falu_float_i),
    .falu_stall_o        (falu_stall_o),
    .wb_valid_o          (wb_valid_o),
    .wb_ready_i          (wb_ready_i),
    .wb_prd_addr_o       (wb_prd_addr_o),
    .wb_rob_index_o      (wb_rob_index_o),
    .wb_data_o           (wb_data_o),
    .wb_fflags_o         (wb_fflags_o),
    .wb_fflags_valid_o   (wb_fflags_valid_o),
    .wb_float_o          (wb_float_o),
    .overflow_err_o      (overflow_err_o)
  );

  logic [127:0] exp_q [$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] mk_entry(
    input logic [PHY_REG_ADDR_WIDTH-1:0] prd,
    input logic [ROB_INDEX_WIDTH-1:0]    rob,
    input logic [XLEN-1:0]               d,
    input logic [FFLAGS_W-1:0]           ff,
    input logic                          fv,
    input logic                          fl
  );
    logic [FFLAGS_W-1:0] eff;
    eff = fv ? ff : '0;
    return 128'({fl, fv, eff, d, rob, prd});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one response; the model expects acceptance only when not flushing and not full.
  task automatic set_resp(
    input logic [PHY_REG_ADDR_WIDTH-1:0] prd,
    input logic [ROB_INDEX_WIDTH-1:0]    rob,
    input logic [XLEN-1:0]               d,
    input logic [FFLAGS_W-1:0]           ff,
    input logic                          fv,
    input logic                          fl
  );
    falu_resp_valid_i   = 1'b1;
    falu_prd_addr_i     = prd;
    falu_rob_index_i    = rob;
    falu_result_i       = d;
    falu_fflags_i       = ff;
    falu_fflags_valid_i = fv;
    falu_float_i        = fl;
    if (!flush_i && exp_q.size() < DEPTH) exp_q.push_back(mk_entry(prd, rob, d, ff, fv, fl));
  endtask

  task automatic push_resp(
    input logic [PHY_REG_ADDR_WIDTH-1:0] prd,
    input logic [ROB_INDEX_WIDTH-1:0]    rob,
    input logic [XLEN-1:0]               d,
    input logic [FFLAGS_W-1:0]           ff,
    input logic                          fv,
    input logic                          fl
  );
    set_resp(prd, rob, d, ff, fv, fl);
    step();
    falu_resp_valid_i = 1'b0;
  endtask

  // Handshake monitor: every accepted head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush_i && wb_valid_o && wb_ready_i) begin
      if (exp_q.size() == 0) check_val("wb_spurious", 128'(1'b1), 128'(1'b0));
      else check_val("wb_entry",
                     128'({wb_float_o, wb_fflags_valid_o, wb_fflags_o, wb_data_o,
                           wb_rob_index_o, wb_prd_addr_o}),
                     exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0;
    falu_resp_valid_i = 1'b0; falu_prd_addr_i = '0; falu_rob_index_i = '0;
    falu_result_i = '0; falu_fflags_i = '0; falu_fflags_valid_i = 1'b0; falu_float_i = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    check_val("rst_valid", 128'(wb_valid_o), 128'(1'b0));
    check_val("rst_stall", 128'(falu_stall_o), 128'(1'b0));
    check_val("rst_ovf", 128'(overflow_err_o), 128'(1'b0));
    check_val("rst_data", 128'(wb_data_o), 128'(0));

    // Single response latency
    wb_ready_i = 1'b1;
    set_resp(7'd5, 6'd3, 64'h3FF0_0000_0000_0000, 5'd0, 1'b0, 1'b1);
    #2;
    check_val("t1_valid_n", 128'(wb_valid_o), 128'(BYP));
    step();
    falu_resp_valid_i = 1'b0;
    check_val("t1_valid_n1", 128'(wb_valid_o), 128'(!BYP));
    repeat (2) step();
    check_val("t1_drained", 128'(exp_q.size()), 128'(0));

    // Fill to full with ready low, then drain in order
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_resp(PHY_REG_ADDR_WIDTH'(i + 10), ROB_INDEX_WIDTH'(i + 20),
                64'hA000_0000_0000_0000 + 64'(i), 5'(i), 1'b1, i[0]);
      check_val("t2_stall", 128'(falu_stall_o), 128'(i == 3));
    end
    wb_ready_i = 1'b1;
    check_val("t2_stall_hold", 128'(falu_stall_o), 128'(1'b1));
    step();
    check_val("t2_stall_drop", 128'(falu_stall_o), 128'(1'b0));
    repeat (4) step();
    check_val("t2_drained", 128'(exp_q.size()), 128'(0));
    check_val("t2_idle", 128'(wb_valid_o), 128'(1'b0));

    // Push while full: dropped, sticky error, contents intact
    wb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      push_resp(PHY_REG_ADDR_WIDTH'(i + 40), ROB_INDEX_WIDTH'(i + 1),
                64'hB000_0000_0000_0000 + 64'(i), 5'd0, 1'b0, 1'b0);
    check_val("t3_ovf_pre", 128'(overflow_err_o), 128'(1'b0));
    push_resp(7'd99, 6'd63, 64'hDEAD_BEEF_DEAD_BEEF, 5'h1F, 1'b1, 1'b1);
    check_val("t3_ovf", 128'(overflow_err_o), 128'(1'b1));
    check_val("t3_stall", 128'(falu_stall_o), 128'(1'b1));
    repeat (3) step();
    check_val("t3_ovf_sticky", 128'(overflow_err_o), 128'(1'b1));
    wb_ready_i = 1'b1;
    repeat (6) step();
    check_val("t3_drained", 128'(exp_q.size()), 128'(0));
    check_val("t3_ovf_kept", 128'(overflow_err_o), 128'(1'b1));

    // Flush with three buffered and a concurrent push/pop
    wb_ready_i = 1'b0;
    for (int i = 0; i < 3; i++)
      push_resp(PHY_REG_ADDR_WIDTH'(i + 60), ROB_INDEX_WIDTH'(i + 30),
                64'hC000_0000_0000_0000 + 64'(i), 5'd2, 1'b1, 1'b1);
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    set_resp(7'd77, 6'd7, 64'h7777_7777_7777_7777, 5'd0, 1'b0, 1'b0);
    step();
    flush_i = 1'b0;
    falu_resp_valid_i = 1'b0;
    exp_q.delete();
    check_val("t4_valid", 128'(wb_valid_o), 128'(1'b0));
    check_val("t4_stall", 128'(falu_stall_o), 128'(1'b0));
    check_val("t4_ovf_kept", 128'(overflow_err_o), 128'(1'b1));
    push_resp(7'd88, 6'd8, 64'h8888_0000_0000_8888, 5'd4, 1'b1, 1'b0);
    repeat (3) step();
    check_val("t4_post_flush", 128'(exp_q.size()), 128'(0));

    // fflags masking
    wb_ready_i = 1'b0;
    push_resp(7'd1, 6'd1, 64'h1, 5'b11111, 1'b0, 1'b1);
    push_resp(7'd2, 6'd2, 64'h2, 5'b00001, 1'b1, 1'b1);
    check_val("t5_valid", 128'(wb_valid_o), 128'(1'b1));
    check_val("t5_ff_masked", 128'(wb_fflags_o), 128'(5'b00000));
    wb_ready_i = 1'b1;
    step();
    check_val("t5_ff_nx", 128'(wb_fflags_o), 128'(5'b00001));
    repeat (2) step();
    check_val("t5_drained", 128'(exp_q.size()), 128'(0));

    // Continuous streaming across pointer wrap, then reset mid-stream
    wb_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push_resp(PHY_REG_ADDR_WIDTH'($urandom), ROB_INDEX_WIDTH'($urandom),
                {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom));
      check_val("t6_nostall", 128'(falu_stall_o), 128'(1'b0));
    end
    set_resp(7'd33, 6'd33, 64'h3333_3333_3333_3333, 5'd3, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    falu_resp_valid_i = 1'b0;
    exp_q.delete();
    check_val("t6_rst_valid", 128'(wb_valid_o), 128'(1'b0));
    check_val("t6_rst_data", 128'(wb_data_o), 128'(0));
    check_val("t6_rst_rob", 128'(wb_rob_index_o), 128'(0));
    check_val("t6_rst_stall", 128'(falu_stall_o), 128'(1'b0));
    check_val("t6_rst_ovf", 128'(overflow_err_o), 128'(1'b0));
    step();
    check_val("t6_rst_idle", 128'(wb_valid_o), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
